// File: rtl/tmds_decoder.sv
// One TMDS channel decoder: finds the 10-bit symbol boundary in the
// deserialized stream using control tokens, locks onto it, then decodes
// each symbol to video data or control bits with a data-enable flag.
module tmds_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int UNLOCK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_in,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(UNLOCK_TIMEOUT + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(LOCK_COUNT - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(UNLOCK_TIMEOUT - 1);

  // Control tokens, written MSB..LSB.
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    r0;
  logic [9:0]    r1;
  logic [TW-1:0] timer;
  logic [RW-1:0] run;
  logic [IW-1:0] idle;

  logic [19:0]   pair;
  logic [9:0]    win;
  logic          is_tok;
  logic [1:0]    tok_ctrl;
  logic [7:0]    q;
  logic [7:0]    dec;
  logic [3:0]    next_offset;

  // Two consecutive words form a 20-bit serial history; older word in the low bits.
  assign pair = {r0, r1};
  assign win  = 10'(pair >> offset);

  // Offset advance is modulo 10.
  assign next_offset = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  // Classify the current window as one of the four control tokens.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (win)
      TOK_00:  tok_ctrl = 2'b00;
      TOK_01:  tok_ctrl = 2'b01;
      TOK_10:  tok_ctrl = 2'b10;
      TOK_11:  tok_ctrl = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    q      = win[7:0] ^ {8{win[9]}};
    dec    = 8'h00;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = win[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Input pipeline, alignment state machine and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low, checked before anything else on the edge.
    if (!rst) begin
      state  <= ST_SEARCH;
      offset <= 4'd0;
      timer  <= '0;
      run    <= '0;
      idle   <= '0;
      r0     <= '0;
      r1     <= '0;
      data   <= 8'h00;
      ctrl   <= 2'b00;
      de     <= 1'b0;
      locked <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r0 <= raw_in;
      r1 <= r0;
      case (state)
        ST_SEARCH: begin
          locked <= 1'b0;
          de     <= 1'b0;
          data   <= 8'h00;
          ctrl   <= 2'b00;
          if (is_tok) begin
            state <= ST_VERIFY;
            run   <= RW'(1);
          end else if (timer == TIMER_LAST) begin
            offset <= next_offset;
            timer  <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_VERIFY: begin
          de   <= 1'b0;
          data <= 8'h00;
          if (is_tok) begin
            run <= run + 1'b1;
            if (run == RUN_LAST) begin
              state  <= ST_LOCKED;
              idle   <= '0;
              locked <= 1'b1;
              ctrl   <= tok_ctrl;
            end else begin
              locked <= 1'b0;
              ctrl   <= 2'b00;
            end
          end else begin
            state  <= ST_SEARCH;
            offset <= next_offset;
            timer  <= '0;
            run    <= '0;
            locked <= 1'b0;
            ctrl   <= 2'b00;
          end
        end
        ST_LOCKED: begin
          if (is_tok) begin
            idle   <= '0;
            locked <= 1'b1;
            de     <= 1'b0;
            data   <= 8'h00;
            ctrl   <= tok_ctrl;
          end else if (idle == IDLE_LAST) begin
            state  <= ST_SEARCH;
            offset <= next_offset;
            timer  <= '0;
            locked <= 1'b0;
            de     <= 1'b0;
            data   <= 8'h00;
            ctrl   <= 2'b00;
          end else begin
            idle   <= idle + 1'b1;
            locked <= 1'b1;
            de     <= 1'b1;
            data   <= dec;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
          de     <= 1'b0;
          data   <= 8'h00;
          ctrl   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: a serial-bit reference model
// follows the alignment rules and predicts every output each cycle, with
// directed checks on the lock, misalignment, abort, loss and reset cases.
module tb_tmds_decoder;

  localparam int LC = 8;
  localparam int ST = 64;
  localparam int UT = 256;

  localparam logic [9:0] D1C0 = 10'h1C0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] raw_in = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  tmds_decoder #(
    .LOCK_COUNT    (LC),
    .SEARCH_TIMEOUT(ST),
    .UNLOCK_TIMEOUT(UT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_in(raw_in),
    .data  (data),
    .ctrl  (ctrl),
    .de    (de),
    .locked(locked),
    .offset(offset)
  );

  always #5 clk = ~clk;

  logic [9:0] toks [4];
  initial begin
    toks[0] = 10'b1101010100;
    toks[1] = 10'b0010101011;
    toks[2] = 10'b0101010100;
    toks[3] = 10'b1010101011;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Serial history of the last 20 received bits, earliest first.
  bit  rxq[$];
  int  m_mode;     // 0 hunting, 1 confirming, 2 locked
  int  m_off, m_timer, m_run, m_idle;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  logic       e_de, e_locked;

  function automatic logic [7:0] tmds_dec(input logic [9:0] w);
    logic [7:0] qq, dd;
    qq = w[9] ? ~w[7:0] : w[7:0];
    dd = qq ^ {qq[6:0], 1'b0};
    if (!w[8]) dd = dd ^ 8'hFE;
    return dd;
  endfunction

  always @(posedge clk) begin
    logic [9:0] w;
    int tok;
    if (!rst) begin
      m_mode = 0; m_off = 0; m_timer = 0; m_run = 0; m_idle = 0;
      rxq = {};
      for (int k = 0; k < 20; k++) rxq.push_back(1'b0);
      e_data = 8'h00; e_ctrl = 2'b00; e_de = 1'b0; e_locked = 1'b0;
    end else begin
      for (int k = 0; k < 10; k++) w[k] = rxq[m_off + k];
      tok = -1;
      for (int t = 0; t < 4; t++) if (w == toks[t]) tok = t;
      case (m_mode)
        0: if (tok >= 0) begin m_mode = 1; m_run = 1; end
           else if (m_timer == ST - 1) begin m_off = (m_off + 1) % 10; m_timer = 0; end
           else m_timer++;
        1: if (tok >= 0) begin
             m_run++;
             if (m_run == LC) begin m_mode = 2; m_idle = 0; end
           end else begin
             m_mode = 0; m_off = (m_off + 1) % 10; m_timer = 0; m_run = 0;
           end
        default: if (tok >= 0) m_idle = 0;
           else if (m_idle == UT - 1) begin m_mode = 0; m_off = (m_off + 1) % 10; m_timer = 0; end
           else m_idle++;
      endcase
      if (m_mode == 2) begin
        if (tok >= 0) begin e_de = 1'b0; e_data = 8'h00; e_ctrl = 2'(tok); end
        else begin e_de = 1'b1; e_data = tmds_dec(w); end
      end else begin
        e_de = 1'b0; e_data = 8'h00; e_ctrl = 2'b00;
      end
      e_locked = (m_mode == 2);
      for (int k = 0; k < 10; k++) rxq.push_back(raw_in[k]);
      for (int k = 0; k < 10; k++) void'(rxq.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  bit txq[$];

  task automatic push_sym(input logic [9:0] w);
    for (int k = 0; k < 10; k++) txq.push_back(w[k]);
  endtask

  // One clock: drive next 10 serial bits, then compare all outputs to the model.
  task automatic tick();
    logic [9:0] w;
    w = '0;
    for (int k = 0; k < 10; k++) w[k] = (txq.size() > 0) ? txq.pop_front() : 1'b0;
    raw_in = w;
    @(posedge clk);
    @(negedge clk);
    check("data",   32'(data),   32'(e_data));
    check("ctrl",   32'(ctrl),   32'(e_ctrl));
    check("de",     32'(de),     32'(e_de));
    check("locked", 32'(locked), 32'(e_locked));
    check("offset", 32'(offset), 32'(m_off));
  endtask

  task automatic send(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      push_sym(w);
      while (txq.size() >= 10) tick();
    end
  endtask

  task automatic do_reset(input int cycles);
    txq = {};
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      push_sym(10'($urandom));
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_off, steps, de_cnt;
    bit seen_lock, fell;

    @(negedge clk);

    // 1. Reset with random input, then quiet data without tokens.
    do_reset(3);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_data",   32'(data),   32'd0);
    send(D1C0, 6);
    check("idle_de", 32'(de), 32'd0);

    // 2. Aligned lock and decode.
    do_reset(2);
    send(toks[0], 8);
    send(D1C0, 2);
    check("lock_on_8th", 32'(locked), 32'd1);
    check("lock_ctrl",   32'(ctrl),   32'd0);
    check("lock_de",     32'(de),     32'd0);
    send(D1C0, 18);
    check("dec_de",   32'(de),   32'd1);
    check("dec_data", 32'(data), 32'h40);
    send(toks[1], 1);
    send(toks[2], 1);
    send(toks[3], 1);
    check("tok1_ctrl", 32'(ctrl), 32'd1);
    check("tok1_de",   32'(de),   32'd0);
    send(D1C0, 1);
    check("tok2_ctrl", 32'(ctrl), 32'd2);
    send(D1C0, 1);
    check("tok3_ctrl", 32'(ctrl), 32'd3);
    send(D1C0, 1);
    check("hold_ctrl", 32'(ctrl), 32'd3);
    check("hold_data", 32'(data), 32'h40);

    // 3. Misalignment by three bits.
    do_reset(2);
    for (int k = 0; k < 3; k++) txq.push_back(1'($urandom));
    prev_off = 0;
    steps = 0;
    for (int line = 0; line < 6; line++) begin
      for (int i = 0; i < 64; i++) begin
        send(i < 16 ? toks[0] : D1C0, 1);
        if (offset != 4'(prev_off)) begin
          check("offset_step", 32'(offset), 32'(prev_off + 1));
          prev_off = int'(offset);
          steps++;
        end
      end
    end
    check("mis_steps",  32'(steps),  32'd3);
    check("mis_locked", 32'(locked), 32'd1);
    check("mis_offset", 32'(offset), 32'd3);

    // 4. Verify abort after five tokens.
    do_reset(2);
    send(toks[0], 5);
    send(D1C0, 3);
    check("abort_locked", 32'(locked), 32'd0);
    check("abort_offset", 32'(offset), 32'd1);

    // 5. Lock loss after UT non-token cycles.
    do_reset(2);
    send(toks[0], 8);
    seen_lock = 0;
    fell = 0;
    de_cnt = 0;
    for (int i = 0; i < 400 && !fell; i++) begin
      send(D1C0, 1);
      if (locked) begin
        seen_lock = 1;
        if (de) de_cnt++;
      end else if (seen_lock) begin
        fell = 1;
      end
    end
    check("loss_fell",   32'(fell),   32'd1);
    check("loss_de_cnt", 32'(de_cnt), 32'(UT - 1));
    check("loss_de_off", 32'(de),     32'd0);
    check("loss_offset", 32'(offset), 32'd1);

    // 6. Reset pulse while locked.
    do_reset(2);
    send(toks[0], 8);
    send(D1C0, 5);
    check("pre_de", 32'(de), 32'd1);
    rst = 1'b0;
    send(D1C0, 1);
    rst = 1'b1;
    check("mid_locked", 32'(locked), 32'd0);
    check("mid_de",     32'(de),     32'd0);
    check("mid_data",   32'(data),   32'd0);
    check("mid_offset", 32'(offset), 32'd0);
    send(toks[0], 9);
    check("relock_7th", 32'(locked), 32'd0);
    send(D1C0, 1);
    check("relock_8th", 32'(locked), 32'd1);

    // 7. Random shift, random token bursts and random data words.
    do_reset(2);
    begin
      int s;
      s = int'($urandom_range(0, 9));
      for (int k = 0; k < s; k++) txq.push_back(1'($urandom));
    end
    for (int b = 0; b < 24; b++) begin
      int nt, nd;
      nt = int'($urandom_range(4, 14));
      nd = int'($urandom_range(1, 40));
      for (int i = 0; i < nt; i++) send(toks[$urandom_range(0, 3)], 1);
      for (int i = 0; i < nd; i++) send(10'($urandom), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the TMDS encode/serialize path: one TMDS channel decoder for the HDMI/DVI input path.
- Takes raw 10-bit words from a 1:10 deserializer. Word boundaries are unknown, so it searches for symbol alignment using control tokens and locks.
- Once locked, it decodes each symbol to 8-bit video data or 2-bit control data, with a data-enable flag. Three instances (B, G, R) sit between the deserializer and the pixel-domain video sink.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens at one offset required to declare lock.
- SEARCH_TIMEOUT, 1024: cycles spent at one offset without seeing a token before advancing the offset.
- UNLOCK_TIMEOUT, 4096: cycles without any control token while locked before lock is dropped.

Ports:
- clk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-low.
- raw_in  in  10  deserialized bits. raw_in[0] is the earliest received bit; serial order is LSB first.
- data  out  8  decoded video byte.
- ctrl  out  2  decoded control bits: {c1,c0}, i.e. vsync/hsync on the blue channel.
- de  out  1  1 = data is valid video; 0 = blanking or unlocked.
- locked  out  1  alignment lock status.
- offset  out  4  current bit offset, 0..9.

Behaviour:
- Reset: rst=0 at a rising edge gives the following on the next cycle:
  - state=SEARCH, offset=0, all timers and run counters 0;
  - pipeline registers r0 and r1 = 0;
  - data=0, ctrl=0, de=0, locked=0.
- Reset takes priority over every other event, including mid-lock.
- Pipeline:
  - r0 <= raw_in; r1 <= r0.
  - win = bits [offset+9 : offset] of the 20-bit value {r0, r1}, with r1 in the low bits.
  - All outputs are registered from win.
  - Latency: at offset 0, a symbol contained in raw_in sampled at edge t appears on the outputs after edge t+2.
- Token detect (MSB..LSB): 1101010100 -> 00; 0010101011 -> 01; 0101010100 -> 10; 1010101011 -> 11. is_tok = win matches any of the four.
- Data decode:
  - q = win[7:0] XOR {8{win[9]}}.
  - d[0] = q[0].
  - For i = 1..7: d[i] = q[i]^q[i-1] when win[8]=1, otherwise ~(q[i]^q[i-1]).
- State SEARCH:
  - is_tok: go to VERIFY, run=1.
  - Otherwise timer++. When timer reaches SEARCH_TIMEOUT-1: offset = (offset==9 ? 0 : offset+1), timer=0.
- State VERIFY:
  - is_tok: run++. When run reaches LOCK_COUNT, go to LOCKED and clear idle.
  - Non-token: go to SEARCH, advance offset (wrapping 9 -> 0), timer=0, run=0.
- State LOCKED:
  - is_tok: idle=0.
  - Otherwise idle++. When idle reaches UNLOCK_TIMEOUT-1: go to SEARCH, advance offset, clear timer.
  - Offset never changes while in LOCKED.
- Outputs:
  - locked is registered. It is 1 on the same edge that registers the outputs for the LOCK_COUNT-th token.
  - While locked=1:
    - is_tok: de=0, ctrl=token value, data=0.
    - Otherwise: de=1, data=decoded byte, ctrl holds its last value.
  - While locked=0: de=0, data=0, ctrl=0.
  - The cycle that unlocks already outputs de=0.
- Counter widths: $clog2(parameter+1). Offset arithmetic is modulo 10; values 10..15 never occur.

Test Plan:
1. Reset: rst=0 for 3 cycles with random raw_in -> locked=0, de=0, data=0x00, ctrl=0, offset=0. These hold until tokens arrive.
2. Aligned lock and decode:
   - Stimulus: offset-0 stream of 8× 1101010100, then 20× 0x1C0, then one each of 0010101011, 0101010100, 1010101011.
   - Response: locked=1 on the 8th token output with ctrl=00. Then de=1 and data=0x40 for 20 cycles. Then de=0 with ctrl=01, 10, 11 respectively. All at 2-cycle latency.
3. Misalignment:
   - Stimulus: SEARCH_TIMEOUT=64; repeating line of 16× 1101010100 + 48× 0x1C0, serial stream shifted by 3 bits.
   - Response: offset steps 0 -> 1 -> 2 -> 3, then locked=1 with offset=3. While locked, data=0x40 with de=1.
4. Verify abort: from reset, 5 aligned tokens, then 0x1C0 -> locked stays 0; state returns to SEARCH with offset 0 -> 1.
5. Lock loss: after lock, feed only 0x1C0 with UNLOCK_TIMEOUT=256 -> locked falls and de=0 on the 256th non-token cycle; offset advances by 1.
6. Reset mid-lock: while locked with de=1, pulse rst=0 for one edge -> next cycle locked=0, de=0, data=0, offset=0; relock needs 8 fresh tokens.
